// File: rtl/seven_segment_fun1.sv
// seven_segment_fun1: button-driven 7-segment animation player with speed control.
// Define SEVEN_SEGMENT_FUN1_DEBOUNCE_EN to add a DEB_CYCLES stability filter on buttons.

module seven_segment_fun1 #(
    parameter int TICK_DIV   = 1000,
    parameter int DEB_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    localparam int PW = $clog2(TICK_DIV * 128);

    logic [3:0]    sync1, sync2, lvl, lvl_q, armed, fire;
    logic [1:0]    prime_cnt;
    logic [2:0]    anim, anim_d, speed, speed_d;
    logic [3:0]    frame, last;
    logic [PW-1:0] pre_cnt, period_m1;
    logic          anim_chg, spd_chg, wrap, step, dp, dp_r;
    logic [6:0]    seg_r;
    logic          unused;

    assign unused = &{1'b0, ui_in[7:4], uio_in, ena};

    // A button only arms once it is seen released after the synchronizer has
    // filled, so a press held through reset cannot fire on release of rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            lvl_q     <= '0;
            armed     <= '0;
            prime_cnt <= '0;
        end else begin
            sync1 <= ui_in[3:0];
            sync2 <= sync1;
            lvl_q <= lvl;
            if (prime_cnt != 2'd2) prime_cnt <= prime_cnt + 2'd1;
            else                   armed     <= armed | ~sync2;
        end
    end

`ifdef SEVEN_SEGMENT_FUN1_DEBOUNCE_EN
    localparam int            DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_cnt [4];
    logic [3:0]    deb_lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_lvl <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i] <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign lvl = deb_lvl;
`else
    localparam int unused_deb = DEB_CYCLES;

    assign lvl = sync2;
`endif

    assign fire = lvl & ~lvl_q & armed;

    always_comb begin
        anim_d  = anim;
        speed_d = speed;
        unique case (1'b1)
            fire[0] & ~fire[1]: anim_d = anim + 3'd1;
            fire[1] & ~fire[0]: anim_d = anim - 3'd1;
            default: ;
        endcase
        unique case (1'b1)
            fire[2] & ~fire[3] & (speed != 3'd7): speed_d = speed + 3'd1;
            fire[3] & ~fire[2] & (speed != 3'd0): speed_d = speed - 3'd1;
            default: ;
        endcase
    end

    assign anim_chg  = anim_d != anim;
    assign spd_chg   = speed_d != speed;
    assign period_m1 = PW'((TICK_DIV << (3'd7 - speed)) - 1);
    assign wrap      = pre_cnt == period_m1;
    assign step      = wrap & ~anim_chg & ~spd_chg;

    always_comb begin
        last = 4'd5;
        unique case (anim)
            3'd2: last = 4'd15;
            3'd3: last = 4'd7;
            3'd4: last = 4'd1;
            3'd6: last = 4'd6;
            3'd7: last = 4'd3;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anim    <= 3'd0;
            speed   <= 3'd3;
            frame   <= 4'd0;
            pre_cnt <= '0;
            dp      <= 1'b0;
        end else begin
            anim  <= anim_d;
            speed <= speed_d;
            if (anim_chg || spd_chg || wrap) pre_cnt <= '0;
            else                             pre_cnt <= pre_cnt + PW'(1);
            if (anim_chg)  frame <= 4'd0;
            else if (step) frame <= (frame == last) ? 4'd0 : frame + 4'd1;
            if (step) dp <= ~dp;
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        g = 7'h00;
        unique case (d)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] glyph(input logic [2:0] a, input logic [3:0] f);
        logic [6:0] g;
        g = 7'h00;
        unique case (a)
            3'd0: g = 7'h01 << f;
            3'd1: g = (f == 4'd0) ? 7'h01 : 7'h40 >> f;
            3'd2: g = hex_glyph(f);
            3'd3: begin
                case (f)
                    4'd0:    g = 7'h01;
                    4'd1:    g = 7'h02;
                    4'd2:    g = 7'h40;
                    4'd3:    g = 7'h10;
                    4'd4:    g = 7'h08;
                    4'd5:    g = 7'h04;
                    4'd6:    g = 7'h40;
                    4'd7:    g = 7'h20;
                    default: g = 7'h00;
                endcase
            end
            3'd4: g = f[0] ? 7'h00 : 7'h7F;
            3'd5: g = (f == 4'd5) ? 7'h21 : 7'h03 << f;
            3'd6: g = (f == 4'd6) ? 7'h00 : (7'h02 << f) - 7'h01;
            3'd7: g = f[0] ? 7'h40 : (f[1] ? 7'h08 : 7'h01);
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= 7'h01;
            dp_r  <= 1'b0;
        end else begin
            seg_r <= glyph(anim, frame);
            dp_r  <= dp;
        end
    end

    assign uo_out  = {dp_r, seg_r};
    assign uio_out = {1'b0, step, speed, anim};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_seven_segment_fun1.sv
// tb_seven_segment_fun1: directed checks of seven_segment_fun1 with default parameters.
// Build with SEVEN_SEGMENT_FUN1_DEBOUNCE_EN to exercise the debounce variant.

module tb_seven_segment_fun1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       ena;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_segment_fun1 dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int b, input int hold, input int rel);
        ui_in[b] = 1'b1;
        tick(hold);
        ui_in[b] = 1'b0;
        tick(rel);
    endtask

    int         idx_exp [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    logic [6:0] g0      [8]  = '{7'h01, 7'h01, 7'h3F, 7'h01,
                                 7'h7F, 7'h03, 7'h01, 7'h01};
    logic [6:0] hexg    [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                                 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                 7'h39, 7'h5E, 7'h79, 7'h71};

    initial begin
        int  n;
        int  ea;
        logic found;

        rst    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        tick(5);
        chk("rst_uo", uo_out, 8'h01);
        chk("rst_uio", uio_out, 8'h18);
        chk("uio_oe", uio_oe, 8'hFF);

        rst = 1'b0;
        tick(15990);
        chk("pre_step_uo", uo_out, 8'h01);
        tick(15);
        chk("first_step_uo", uo_out, 8'h82);
        chk("first_step_uio", uio_out, 8'h18);

        for (int i = 0; i < 10; i++) begin
            ui_in[0] = 1'b1;
            tick(1000);
            chk("anim_hold", uio_out[2:0], idx_exp[i]);
            chk("anim_frame0", uo_out[6:0], g0[idx_exp[i]]);
            ui_in[0] = 1'b0;
            tick(1000);
            chk("anim_release", uio_out[2:0], idx_exp[i]);
        end

        for (int i = 0; i < 5; i++) begin
            press(2, 400, 400);
            chk("speed_up", uio_out[5:3], (i < 4) ? 4 + i : 7);
        end

        found = 1'b0;
        for (int k = 0; k < 1100 && !found; k++) begin
            tick(1);
            found = uio_out[6];
        end
        chk("step_seen", found, 1);
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 1100 && !found; k++) begin
            tick(1);
            n++;
            found = uio_out[6];
        end
        chk("step_period_s7", n, 1000);

        press(1, 400, 400);
        chk("anim_prev", uio_out[2:0], 1);
        ui_in[0] = 1'b1;
        tick(400);
        ui_in[0] = 1'b0;
        tick(103);
        for (int j = 0; j < 17; j++) begin
            chk("hex_seq", uo_out[6:0], hexg[j % 16]);
            tick(1000);
        end

        for (int i = 0; i < 9; i++) begin
            press(3, 400, 400);
            chk("speed_down", uio_out[5:3], (i < 6) ? 6 - i : 0);
        end

        ui_in[1:0] = 2'b11;
        tick(400);
        ui_in[1:0] = 2'b00;
        tick(400);
        chk("both_buttons", uio_out[2:0], 2);

`ifdef SEVEN_SEGMENT_FUN1_DEBOUNCE_EN
        ea = 2;
`else
        ea = 3;
`endif
        press(0, 100, 400);
        chk("glitch", uio_out[2:0], ea);
        press(0, 1000, 400);
        chk("long_press", uio_out[2:0], ea + 1);

        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_uo", uo_out, 8'h01);
        chk("mid_rst_uio", uio_out, 8'h18);
        ui_in[0] = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1000);
        chk("held_thru_rst", uio_out[2:0], 0);
        ui_in[0] = 1'b0;
        tick(400);
        ui_in[0] = 1'b1;
        tick(400);
        chk("repress_after_rst", uio_out[2:0], 1);
        ui_in[0] = 1'b0;
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_segment_fun1.md
SEVEN_SEGMENT_FUN1 -- requirements
Module: seven_segment_fun1

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000, the base step prescale in clock cycles.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 256, the cycles a button must be stable to be accepted.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock (10 MHz nominal).
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port ui_in, input, 8 bits: [0] next animation, [1] previous animation, [2] speed up, [3] speed down, [7:4] ignored.
REQ-006 The block SHALL have port uo_out, output, 8 bits, 7-segment drive, active-high: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g [7]=dp.
REQ-007 The block SHALL have port uio_in, input, 8 bits, ignored.
REQ-008 The block SHALL have port uio_out, output, 8 bits: [2:0] animation index, [5:3] speed level, [6] step pulse, [7] 0.
REQ-009 The block SHALL have port uio_oe, output, 8 bits, constant 8'hFF.
REQ-010 The block SHALL have port ena, input, 1 bit, ignored.

Function
REQ-011 Each ui_in[3:0] button SHALL pass through a 2-flop synchronizer, then a debounce stage (see Configuration); an action fires once per rising edge of the conditioned level; holding a button gives no repeats.
REQ-012 Animation index (3 bits) SHALL wrap: next from 7 gives 0, previous from 0 gives 7; next and previous firing in the same cycle SHALL give no change.
REQ-013 Speed level (3 bits) SHALL saturate at 0 and 7; up and down firing in the same cycle SHALL give no change.
REQ-014 Step period SHALL be TICK_DIV * 2^(7-speed) cycles; a one-cycle step pulse at period end SHALL advance the frame counter and toggle dp.
REQ-015 An animation change SHALL reset the frame counter to 0 and restart the prescaler; a speed change SHALL restart the prescaler and keep the frame.
REQ-016 Frame sequences (g..a bits), wrapping to frame 0 after the last:
- 0 CW: a,b,c,d,e,f
- 1 CCW: a,f,e,d,c,b
- 2 hex: digits 0..F, standard glyphs (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71)
- 3 figure-8: a,b,g,e,d,c,g,f
- 4 blink: 7F,00
- 5 snake: ab,bc,cd,de,ef,fa
- 6 fill: a,ab,abc,abcd,abcde,abcdef,none
- 7 sweep: a,g,d,g
REQ-017 uo_out[6:0] SHALL be registered, updating the cycle after frame or animation changes.

Reset
REQ-018 While rst is high: animation 0, speed 3, frame 0, prescaler 0, debounce and edge state cleared (buttons treated as released), uo_out=8'h01, uio_out=8'h18.
REQ-019 A button held across reset release SHALL NOT fire until released and pressed again.

Configuration
REQ-020 With macro SEVEN_SEGMENT_FUN1_DEBOUNCE_EN defined, a synchronized button level SHALL be accepted only after DEB_CYCLES consecutive stable cycles (accepted-action latency DEB_CYCLES+4 cycles max); without it, synchronized levels SHALL be edge-detected directly (latency 4 cycles max), and DEB_CYCLES SHALL be unused.

Verification
REQ-021 Reset release -> uo_out=01, uio_out=18; after 16000 cycles uo_out=82 (b lit, dp=1).
REQ-022 Ten 1000-cycle presses of ui_in[0] -> index 0..7 then wraps, ends at 2; uio_out[2:0]=2; frame 0 shown after each press.
REQ-023 Speed-up pressed 5 times from reset -> speed 7 saturated; step pulses every 1000 cycles; speed-down 9 times -> speed 0, period 128000 cycles.
REQ-024 Macro defined, DEB_CYCLES=256: 100-cycle glitch on ui_in[0] -> no change; 1000-cycle press -> exactly one increment.
REQ-025 ui_in[0] and ui_in[1] rising in the same cycle -> index unchanged; rst asserted mid-animation -> immediate return to reset values.
REQ-026 Animation 2 at speed 7 -> uo_out[6:0] sequence 3F,06,5B,...,71,3F with 1000 cycles per frame.
